// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared owner-state enum, client ids and default widths for the ram_arb2 slice
package ram_arb_pkg;
  typedef enum logic [1:0] {NONE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} owner_e;
  localparam logic CID0 = 1'b0;
  localparam logic CID1 = 1'b1;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;
endpackage

// File: rtl/ram_arb2_if.sv
// ram_arb2_if: one client's request/grant/read-return bundle
// master = client side (drives req/we/addr/wdata), slave = arbiter side (drives gnt/rvalid/rdata)
interface ram_arb2_if #(
  parameter int ADDR_W = ram_arb_pkg::DEF_ADDR_W,
  parameter int DATA_W = ram_arb_pkg::DEF_DATA_W
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_arb_rdpipe.sv
// ram_arb_rdpipe: RD_LAT-deep {valid, id} delay line aligning read beats with RAM data, plus per-client rdata/rvalid registers
// ports: clk, rst_n (async active-low), rd_beat_i/rd_id_i (read issued this cycle and by whom),
//        ram_rd_data_i (RAM output), rvalid0_o/rvalid1_o (1-cycle pulses), rdata0_o/rdata1_o (held between pulses)
module ram_arb_rdpipe import ram_arb_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_beat_i,
  input  logic              rd_id_i,
  input  logic [DATA_W-1:0] ram_rd_data_i,
  output logic              rvalid0_o,
  output logic              rvalid1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o
);
  logic [RD_LAT-1:0] vld_q, vld_d, id_q, id_d;
  logic              tap0, tap1, rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  always_comb begin
    vld_d    = vld_q;
    id_d     = id_q;
    vld_d[0] = rd_beat_i;
    id_d[0]  = rd_id_i;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      id_d[i]  = id_q[i-1];
    end
  end
  // the last stage lines up with the cycle in which ram_rd_data carries that beat's word
  assign tap0 = vld_q[RD_LAT-1] && id_q[RD_LAT-1] == CID0;
  assign tap1 = vld_q[RD_LAT-1] && id_q[RD_LAT-1] == CID1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= '0;
      id_q      <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      vld_q     <= vld_d;
      id_q      <= id_d;
      rvalid0_q <= tap0;
      rvalid1_q <= tap1;
      rdata0_q  <= tap0 ? ram_rd_data_i : rdata0_q;
      rdata1_q  <= tap1 ? ram_rd_data_i : rdata1_q;
    end
  end
  assign rvalid0_o = rvalid0_q;
  assign rvalid1_o = rvalid1_q;
  assign rdata0_o  = rdata0_q;
  assign rdata1_o  = rdata1_q;
endmodule

// File: rtl/ram_arb2.sv
// ram_arb2: two-client round-robin arbiter with bounded burst lock sharing one single-port RAM port
// ports: clk, rst_n (async active-low); c0/c1 client bundles (ram_arb2_if.slave);
//        ram_wr_en/ram_rd_en/ram_addr/ram_wr_data to the RAM, ram_rd_data from it (RD_LAT clocks after a read beat)
// optional: define RAM_ARB2_STATS_EN to add saturating counters st_gnt0, st_gnt1 (completed beats) and st_stall (stalled cycles)
module ram_arb2 import ram_arb_pkg::*; #(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_arb2_if.slave         c0,
  ram_arb2_if.slave         c1,
  output logic              ram_wr_en,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  input  logic [DATA_W-1:0] ram_rd_data
`ifdef RAM_ARB2_STATS_EN
  ,
  output logic [15:0]       st_gnt0,
  output logic [15:0]       st_gnt1,
  output logic [15:0]       st_stall
`endif
);
  localparam logic [3:0] MAXB = 4'(MAX_BURST);
  owner_e            owner_q, owner_d;
  logic              last_q, last_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              keep0, keep1, g0, g1, we;
  always_comb begin
    // a client may keep the port while under its burst budget or while the other side is idle
    keep0       = c0.req && (cnt_q < MAXB || !c1.req);
    keep1       = c1.req && (cnt_q < MAXB || !c0.req);
    // rst_n gating keeps grants low during reset even though they are combinational from req
    g0          = rst_n && c0.req && (owner_q == OWN0 ? keep0 : owner_q == OWN1 ? !keep1 : (!c1.req || last_q == CID1));
    g1          = rst_n && c1.req && (owner_q == OWN1 ? keep1 : owner_q == OWN0 ? !keep0 : (!c0.req || last_q == CID0));
    owner_d     = g0 ? OWN0 : g1 ? OWN1 : NONE;
    last_d      = g0 ? CID0 : g1 ? CID1 : last_q;
    cnt_d       = !(g0 || g1) ? 4'd0 : owner_d != owner_q ? 4'd1 : cnt_q < MAXB ? cnt_q + 4'd1 : cnt_q;
    we          = g1 ? c1.we : c0.we;
    ram_wr_en   = (g0 || g1) && we;
    ram_rd_en   = (g0 || g1) && !we;
    ram_addr    = g0 ? c0.addr : g1 ? c1.addr : addr_q;
    ram_wr_data = g0 ? c0.wdata : g1 ? c1.wdata : wdata_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= NONE;
      last_q  <= CID1;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= ram_addr;
      wdata_q <= ram_wr_data;
    end
  end
  assign c0.gnt = g0;
  assign c1.gnt = g1;
  ram_arb_rdpipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_rdpipe (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_beat_i     (ram_rd_en),
    .rd_id_i       (g1 ? CID1 : CID0),
    .ram_rd_data_i (ram_rd_data),
    .rvalid0_o     (c0.rvalid),
    .rvalid1_o     (c1.rvalid),
    .rdata0_o      (c0.rdata),
    .rdata1_o      (c1.rdata)
  );
`ifdef RAM_ARB2_STATS_EN
  logic [15:0] st_gnt0_q, st_gnt1_q, st_stall_q;
  logic        stall;
  // counted once per cycle even if both clients wait
  assign stall = (c0.req && !g0) || (c1.req && !g1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_gnt0_q  <= '0;
      st_gnt1_q  <= '0;
      st_stall_q <= '0;
    end else begin
      st_gnt0_q  <= (g0 && st_gnt0_q != 16'hFFFF) ? st_gnt0_q + 16'd1 : st_gnt0_q;
      st_gnt1_q  <= (g1 && st_gnt1_q != 16'hFFFF) ? st_gnt1_q + 16'd1 : st_gnt1_q;
      st_stall_q <= (stall && st_stall_q != 16'hFFFF) ? st_stall_q + 16'd1 : st_stall_q;
    end
  end
  assign st_gnt0  = st_gnt0_q;
  assign st_gnt1  = st_gnt1_q;
  assign st_stall = st_stall_q;
`endif
endmodule

// File: tb/tb_ram_arb2.sv
// tb_ram_arb2: directed bench for ram_arb2 with a spec-level grant/read-return model checked every cycle
module tb_ram_arb2;
  localparam int RD_LAT = 2;
  localparam int MAXB   = 4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ram_wr_en, ram_rd_en;
  logic [4:0] ram_addr;
  logic [7:0] ram_wr_data, ram_rd_data;
  ram_arb2_if #(.ADDR_W(5), .DATA_W(8)) c0_if ();
  ram_arb2_if #(.ADDR_W(5), .DATA_W(8)) c1_if ();
`ifdef RAM_ARB2_STATS_EN
  logic [15:0] st_gnt0, st_gnt1, st_stall;
`endif
  ram_arb2 #(.ADDR_W(5), .DATA_W(8), .RD_LAT(RD_LAT), .MAX_BURST(MAXB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .c0          (c0_if),
    .c1          (c1_if),
    .ram_wr_en   (ram_wr_en),
    .ram_rd_en   (ram_rd_en),
    .ram_addr    (ram_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_data (ram_rd_data)
`ifdef RAM_ARB2_STATS_EN
    ,
    .st_gnt0     (st_gnt0),
    .st_gnt1     (st_gnt1),
    .st_stall    (st_stall)
`endif
  );
  always #5 clk = ~clk;
  // RAM with RD_LAT-cycle read latency
  logic [7:0] mem [32];
  logic [7:0] rpipe [RD_LAT];
  always @(posedge clk) begin
    rpipe[0] <= mem[ram_addr];
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
    if (ram_wr_en) mem[ram_addr] <= ram_wr_data;
  end
  assign ram_rd_data = rpipe[RD_LAT-1];
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // model state: owner -1 = none
  typedef struct {int due; int id; logic [7:0] data;} rd_t;
  rd_t        pq[$];
  logic [7:0] rx1[$];
  int         rv0_cnt = 0;
  int         cyc = 0;
  int         m_owner = -1, m_last = 1, m_burst = 0;
  logic [4:0] m_addr = '0;
  logic [7:0] m_wdata = '0, m_rd0 = '0, m_rd1 = '0;
  logic [7:0] m_mem [32];
  function automatic int pick(input bit r0, input bit r1);
    bit r[2];
    r[0] = r0;
    r[1] = r1;
    if (m_owner >= 0 && r[m_owner] && (m_burst < MAXB || !r[1-m_owner])) return m_owner;
    if (m_owner >= 0 && r[1-m_owner]) return 1 - m_owner;
    if (m_owner < 0 && r0 && r1) return 1 - m_last;
    if (m_owner < 0 && (r0 || r1)) return r0 ? 0 : 1;
    return -1;
  endfunction
  always @(negedge clk) begin
    int g;
    bit cwe, ev0, ev1;
    logic [4:0] caddr;
    logic [7:0] cwd;
    if (!rst_n) begin
      m_owner = -1; m_last = 1; m_burst = 0;
      m_addr = '0; m_wdata = '0; m_rd0 = '0; m_rd1 = '0;
      pq.delete();
      chk("rst_ctrl", {c0_if.gnt, c1_if.gnt, ram_wr_en, ram_rd_en, c0_if.rvalid, c1_if.rvalid}, 0);
      chk("rst_rdata", {c0_if.rdata, c1_if.rdata}, 0);
      chk("rst_ram", {ram_addr, ram_wr_data}, 0);
    end else begin
      g = pick(c0_if.req, c1_if.req);
      cwe = (g == 1) ? c1_if.we : c0_if.we;
      caddr = (g == 1) ? c1_if.addr : c0_if.addr;
      cwd = (g == 1) ? c1_if.wdata : c0_if.wdata;
      if (g >= 0) begin
        m_addr = caddr;
        m_wdata = cwd;
      end
      chk("gnt", {c0_if.gnt, c1_if.gnt}, {g == 0, g == 1});
      chk("ram_en", {ram_wr_en, ram_rd_en}, {g >= 0 && cwe, g >= 0 && !cwe});
      chk("ram_addr", ram_addr, m_addr);
      chk("ram_wdata", ram_wr_data, m_wdata);
      ev0 = 0; ev1 = 0;
      if (pq.size() > 0 && pq[0].due == cyc) begin
        if (pq[0].id == 0) begin ev0 = 1; m_rd0 = pq[0].data; end
        else begin ev1 = 1; m_rd1 = pq[0].data; end
        void'(pq.pop_front());
      end
      chk("rvalid", {c0_if.rvalid, c1_if.rvalid}, {ev0, ev1});
      chk("rdata0", c0_if.rdata, m_rd0);
      chk("rdata1", c1_if.rdata, m_rd1);
      if (c1_if.rvalid) rx1.push_back(c1_if.rdata);
      if (c0_if.rvalid) rv0_cnt++;
      if (g >= 0) begin
        if (cwe) m_mem[caddr] = cwd;
        else pq.push_back('{cyc + RD_LAT + 1, g, m_mem[caddr]});
        if (g == m_owner) m_burst = m_burst < MAXB ? m_burst + 1 : MAXB;
        else begin m_owner = g; m_last = g; m_burst = 1; end
      end else begin
        m_owner = -1;
        m_burst = 0;
      end
    end
    cyc++;
  end
  task automatic drive(input int c, input bit req, input bit we, input int addr, input int data);
    if (c == 0) begin
      c0_if.req = req; c0_if.we = we; c0_if.addr = 5'(addr); c0_if.wdata = 8'(data);
    end else begin
      c1_if.req = req; c1_if.we = we; c1_if.addr = 5'(addr); c1_if.wdata = 8'(data);
    end
  endtask
  task automatic beat(input int c, input bit we, input int addr, input int data, output bit ok, output int seen);
    drive(c, 1'b1, we, addr, data);
    ok = 0;
    seen = -1;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      ok = (c == 0) ? c0_if.gnt : c1_if.gnt;
      seen = int'(ram_addr);
    end
    @(posedge clk);
    #1;
    drive(c, 1'b0, we, addr, data);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    bit ok, g0s, g1s, found, rv;
    int a, k0, k1;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    // c0 fills the RAM
    for (int i = 0; i < 32; i++) begin
      beat(0, 1, i, i + 1, ok, a);
      chk("p1_c0_gnt", ok, 1);
      chk("p1_ram_addr", a, i);
    end
    // c1 reads it back
    rx1.delete();
    rv0_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      beat(1, 0, i, 0, ok, a);
      chk("p2_c1_gnt", ok, 1);
    end
    repeat (RD_LAT + 3) @(posedge clk);
    #1;
    chk("p2_rx_count", rx1.size(), 32);
    for (int i = 0; i < 32; i++)
      if (i < rx1.size()) chk("p2_c1_rdata", rx1[i], i + 1);
    chk("p2_c0_rvalid_cnt", rv0_cnt, 0);
    // continuous contention: bursts of MAXB, c0 first
    k0 = 0;
    k1 = 0;
    drive(0, 1, 1, 16, 8'hA0);
    drive(1, 1, 1, 24, 8'hB0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      g0s = c0_if.gnt;
      g1s = c1_if.gnt;
      chk("p3_gnt0", g0s, ((k / 4) % 2) == 0);
      chk("p3_gnt1", g1s, ((k / 4) % 2) == 1);
      @(posedge clk);
      #1;
      if (g0s) begin k0++; drive(0, 1, 1, 16 + k0, 8'hA0 + k0); end
      if (g1s) begin k1++; drive(1, 1, 1, 24 + k1, 8'hB0 + k1); end
    end
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    // interleaved reads return in issue order
    beat(0, 0, 5, 0, ok, a);
    chk("p4_c0_gnt", ok, 1);
    beat(1, 0, 9, 0, ok, a);
    chk("p4_c1_gnt", ok, 1);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = c0_if.rvalid;
    end
    chk("p4_c0_rvalid_seen", found, 1);
    chk("p4_c0_rdata", c0_if.rdata, 8'h06);
    chk("p4_c1_not_yet", c1_if.rvalid, 0);
    @(negedge clk);
    chk("p4_c1_rvalid", c1_if.rvalid, 1);
    chk("p4_c1_rdata", c1_if.rdata, 8'h0A);
    chk("p4_c0_rvalid_off", c0_if.rvalid, 0);
    @(posedge clk);
    #1;
    // reset with a read in flight
    beat(0, 0, 3, 0, ok, a);
    rst_n = 1'b0;
    @(negedge clk);
    chk("p5_rst_outs", {c0_if.gnt, c1_if.gnt, ram_wr_en, ram_rd_en, c0_if.rvalid, c1_if.rvalid, ram_addr}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rv = 0;
    repeat (6) begin
      @(negedge clk);
      rv |= c0_if.rvalid | c1_if.rvalid;
    end
    chk("p5_no_rvalid", rv, 0);
    @(posedge clk);
    #1;
    drive(0, 1, 1, 1, 8'h55);
    drive(1, 1, 1, 2, 8'h66);
    @(negedge clk);
    chk("p5_tie_c0", {c0_if.gnt, c1_if.gnt}, 2'b10);
    @(posedge clk);
    #1 drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("p5_then_c1", {c0_if.gnt, c1_if.gnt}, 2'b01);
    @(posedge clk);
    #1 drive(1, 0, 0, 0, 0);
`ifdef RAM_ARB2_STATS_EN
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    k0 = 0;
    k1 = 0;
    drive(0, 1, 1, 16, 8'hC0);
    drive(1, 1, 1, 24, 8'hD0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      g0s = c0_if.gnt;
      g1s = c1_if.gnt;
      @(posedge clk);
      #1;
      if (g0s) begin k0++; drive(0, 1, 1, 16 + k0, 8'hC0 + k0); end
      if (g1s) begin k1++; drive(1, 1, 1, 24 + k1, 8'hD0 + k1); end
    end
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    chk("st_gnt_sum", 32'(st_gnt0) + 32'(st_gnt1), 10);
    chk("st_gnt0", st_gnt0, 4 + 2);
    chk("st_stall", st_stall, 10);
`endif
    repeat (4) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
